readout_deserializer: RTL
=========================

READOUT_DESERIALIZER -- requirements
Module: readout_deserializer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the SPI_CLK rising edge.
REQ-002 SPI_CLK  input  1  readout clock, 40 MHz.
REQ-003 RSTB  input  1  asynchronous active-low full reset.
REQ-004 READOUT_REQ  input  1  single-cycle request to read one channel's six registers.
REQ-005 CNT_SER  input  1  serial data from the channel readout shifter, MSB first.
REQ-006 INST_READOUT  output  1  load strobe to the channel, one cycle per register.
REQ-007 SELECT_REG  output  3  register index to the channel: 0 = trigger_cnt (3 bits, zero-extended to 10); 1..5 = CA..CE.
REQ-008 WORD_DATA  output  10  assembled word.
REQ-009 WORD_ADDR  output  3  index of WORD_DATA.
REQ-010 WORD_VALID  output  1  word available.
REQ-011 WORD_READY  input  1  downstream accepts the word.
REQ-012 BUSY  output  1  sequence in progress.
REQ-013 DONE  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-014 States SHALL be IDLE, LOAD, SHIFT, PUSH and FINISH.
REQ-015 IDLE: READOUT_REQ=1 -> LOAD with idx=0 and BUSY=1 from the next cycle.
REQ-016 LOAD, one cycle: INST_READOUT=1 and SELECT_REG=idx; then -> SHIFT.
REQ-017 SHIFT, exactly 10 cycles: sample CNT_SER each cycle into a 10-bit shift register, shifting left with the first bit as MSB; a 4-bit counter counts 0..9; then -> PUSH.
REQ-018 SELECT_REG SHALL hold idx from LOAD through PUSH.
REQ-019 PUSH: WORD_VALID=1, WORD_DATA=shifted word, WORD_ADDR=idx.
REQ-020 The word and address SHALL be stable while WORD_VALID=1 and WORD_READY=0.
REQ-021 A transfer SHALL occur on a cycle with WORD_VALID & WORD_READY.
REQ-022 After a transfer: idx = last index -> FINISH; otherwise idx+1 -> LOAD.
REQ-023 FINISH, one cycle: DONE=1, BUSY=0 the same cycle, then -> IDLE.
REQ-024 Latency: with WORD_READY held high, a request at cycle 0 gives word 0 valid at cycle 12 and 12 cycles per word; DONE occurs at cycle 73.
REQ-025 READOUT_REQ while BUSY or in FINISH SHALL be ignored and not queued.
REQ-026 WORD_READY held low SHALL stall in PUSH indefinitely with no data loss.
REQ-027 For idx=0, bits 9:3 of the captured word SHALL be passed through unmodified (the channel drives them 0).

Reset
REQ-028 RSTB=0 SHALL, asynchronously and at any state including mid-SHIFT or PUSH, force the following: state IDLE, idx=0, bit counter=0, shift register=0, INST_READOUT=0, SELECT_REG=0, WORD_DATA=0, WORD_ADDR=0, WORD_VALID=0, BUSY=0, DONE=0.
REQ-029 After RSTB releases, the first READOUT_REQ SHALL start a fresh sequence at idx=0.

Configuration
REQ-030 Macro RDO_SKIP_UNUSED_EN, when defined: after word 0 is transferred, latch N = min(word0[2:0], 5); the last index SHALL be N, so CA..(N) are read and unused timestamps are skipped.
REQ-031 With RDO_SKIP_UNUSED_EN and N=0, the sequence SHALL go straight from word 0's transfer to FINISH.
REQ-032 Without RDO_SKIP_UNUSED_EN, the last index SHALL always be 5 and six words SHALL always be read.

Verification
REQ-033 READOUT_REQ, READY=1, CNT_SER patterns 3,0x2AA,0x155,0x3FF,0x000,0x201 -> words at addresses 0..5 with those values; word 0 valid at cycle 12; DONE at cycle 73.
REQ-034 READY=0 for 20 cycles during word 2 -> WORD_VALID and WORD_DATA stay stable; the sequence resumes; all six words are correct.
REQ-035 RSTB pulsed low at SHIFT bit 5 of word 1 -> all outputs are 0 immediately; a new READOUT_REQ returns word 0 first.
REQ-036 READOUT_REQ repeated at cycle 30 of a sequence -> ignored; exactly one DONE.
REQ-037 RDO_SKIP_UNUSED_EN with trigger_cnt=2 -> words at addresses 0,1,2 only; DONE at cycle 37. With trigger_cnt=7 -> six words, clamped to 5.
REQ-038 RDO_SKIP_UNUSED_EN with trigger_cnt=0 -> a single word 0 then DONE at cycle 13.

Source files
------------

// File: rtl/readout_deserializer.sv
// Readout deserializer: loads each channel register, shifts it in MSB first and hands it on over a valid/ready handshake.
// Optional RDO_SKIP_UNUSED_EN: word 0 (trigger_cnt) sets the last register index, so unused timestamps are skipped.
module readout_deserializer (
  input  logic       SPI_CLK,
  input  logic       RSTB,
  input  logic       READOUT_REQ,
  input  logic       CNT_SER,
  output logic       INST_READOUT,
  output logic [2:0] SELECT_REG,
  output logic [9:0] WORD_DATA,
  output logic [2:0] WORD_ADDR,
  output logic       WORD_VALID,
  input  logic       WORD_READY,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [2:0] LAST_REG  = 3'd5;
  localparam logic [3:0] LAST_BIT  = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    PUSH,
    FINISH
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [3:0] bit_cnt;
  logic [9:0] shreg;
  logic [9:0] next_word;
  logic [2:0] final_idx;

  assign next_word = {shreg[8:0], CNT_SER};

`ifdef RDO_SKIP_UNUSED_EN
  logic [2:0] last_idx;
  logic [2:0] word0_last;

  // While word 0 is presented, its trigger count decides the last index directly.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    word0_last = WORD_DATA[2:0];
    if (WORD_DATA[2:0] > LAST_REG) word0_last = LAST_REG;
    final_idx = (idx == 3'd0) ? word0_last : last_idx;
  end
`else
  assign final_idx = LAST_REG;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge SPI_CLK or negedge RSTB) begin
    if (!RSTB) begin
      state        <= IDLE;
      idx          <= 3'd0;
      bit_cnt      <= 4'd0;
      shreg        <= 10'd0;
      INST_READOUT <= 1'b0;
      SELECT_REG   <= 3'd0;
      WORD_DATA    <= 10'd0;
      WORD_ADDR    <= 3'd0;
      WORD_VALID   <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
`ifdef RDO_SKIP_UNUSED_EN
      last_idx     <= LAST_REG;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (READOUT_REQ) begin
            state        <= LOAD;
            idx          <= 3'd0;
            SELECT_REG   <= 3'd0;
            INST_READOUT <= 1'b1;
            BUSY         <= 1'b1;
          end
        end

        LOAD: begin
          INST_READOUT <= 1'b0;
          bit_cnt      <= 4'd0;
          state        <= SHIFT;
        end

        SHIFT: begin
          shreg   <= next_word;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) begin
            WORD_DATA  <= next_word;
            WORD_ADDR  <= idx;
            WORD_VALID <= 1'b1;
            state      <= PUSH;
          end
        end

        PUSH: begin
          // Word and address are held untouched until the handshake completes.
          if (WORD_READY) begin
            WORD_VALID <= 1'b0;
`ifdef RDO_SKIP_UNUSED_EN
            if (idx == 3'd0) last_idx <= final_idx;
`endif
            if (idx == final_idx) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= FINISH;
            end else begin
              idx          <= idx + 3'd1;
              SELECT_REG   <= idx + 3'd1;
              INST_READOUT <= 1'b1;
              state        <= LOAD;
            end
          end
        end

        FINISH: begin
          // Requests arriving here are dropped, not queued.
          DONE       <= 1'b0;
          SELECT_REG <= 3'd0;
          idx        <= 3'd0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
